// File: rtl/jam_pkg.sv
// Shared constants and FSM encoding for the jam cost-ROM arbiter.
package jam_pkg;

    localparam int unsigned JAM_ADDR_W  = 3;
    localparam int unsigned JAM_COST_W  = 7;
    localparam int unsigned NUM_WORKERS = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/jam_rr_picker.sv
// Round-robin first-set-bit search: scans req upward from ptr, wrapping at NUM_REQ.
module jam_rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   idx,
    output logic               found
);

    int unsigned cand;

    // First requester at or after ptr in circular order wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[PTR_W'(cand)]) begin
                idx   = PTR_W'(cand);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jam_cost_rom_arbiter.sv
// Round-robin arbiter sharing one combinational cost ROM between NUM_REQ engines.
// Optional hold timeout: define JAM_ARB_TIMEOUT_EN to add the idle-hold counter
// and the timeout_err output.
module jam_cost_rom_arbiter
    import jam_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_W     = JAM_ADDR_W,
    parameter int unsigned COST_W     = JAM_COST_W,
    parameter int unsigned HOLD_LIMIT = 16
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        rd,
    input  logic [NUM_REQ-1:0]        last,
    input  logic [NUM_REQ*ADDR_W-1:0] w_in,
    input  logic [NUM_REQ*ADDR_W-1:0] j_in,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_w,
    output logic [ADDR_W-1:0]         rom_j,
    input  logic [COST_W-1:0]         rom_cost,
    output logic [COST_W-1:0]         cost_out,
    output logic [NUM_REQ-1:0]        cost_vld,
    output logic                      busy
`ifdef JAM_ARB_TIMEOUT_EN
    ,
    output logic                      timeout_err
`endif
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject out-of-range configurations at elaboration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_LIMIT < 1) begin : g_bad_param
        $error("jam_cost_rom_arbiter: NUM_REQ must be 2..8 and HOLD_LIMIT >= 1");
    end

    state_t              state_q, state_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_d;
    logic [COST_W-1:0]   cost_d;
    logic [NUM_REQ-1:0]  vld_d;
    logic                busy_d;
    logic [ADDR_W-1:0]   w_hold_q, j_hold_q;
    logic [ADDR_W-1:0]   sel_w, sel_j;
    logic [PW-1:0]       pick_idx;
    logic                pick_found;
    logic                rd_hit;

`ifdef JAM_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(HOLD_LIMIT) + 1;
    logic [CW-1:0] hold_q, hold_d;
    logic          tmo_d;
`endif

    jam_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PW)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Owner's worker/job address selection.
    always_comb begin
        sel_w = w_in[ADDR_W-1:0];
        sel_j = j_in[ADDR_W-1:0];
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == PW'(i)) begin
                sel_w = w_in[i*ADDR_W +: ADDR_W];
                sel_j = j_in[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // ROM address follows the owner while granted, otherwise holds its last value.
    assign rom_w  = (state_q == ST_GRANT) ? sel_w : w_hold_q;
    assign rom_j  = (state_q == ST_GRANT) ? sel_j : j_hold_q;

    assign rd_hit = (state_q == ST_GRANT) && rd[owner_q] && req[owner_q];

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cost_d  = cost_out;
        vld_d   = '0;
`ifdef JAM_ARB_TIMEOUT_EN
        hold_d  = hold_q;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    state_d = ST_GRANT;
`ifdef JAM_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (rd_hit) begin
                    cost_d = rom_cost;
                    vld_d  = NUM_REQ'(1) << owner_q;
`ifdef JAM_ARB_TIMEOUT_EN
                    hold_d = '0;
`endif
                    if (last[owner_q]) begin
                        state_d = ST_RELEASE;
                    end
                end else if (!req[owner_q]) begin
                    state_d = ST_RELEASE;
                end
`ifdef JAM_ARB_TIMEOUT_EN
                else begin
                    hold_d = hold_q + CW'(1);
                    if (hold_d == CW'(HOLD_LIMIT)) begin
                        state_d = ST_RELEASE;
                        tmo_d   = 1'b1;
                    end
                end
`endif
            end
            ST_RELEASE: begin
                ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        gnt_d  = (state_d == ST_GRANT) ? (NUM_REQ'(1) << owner_d) : '0;
        busy_d = (state_d != ST_IDLE);
    end

    // State, owner, pointer and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            gnt      <= '0;
            cost_out <= '0;
            cost_vld <= '0;
            busy     <= 1'b0;
            w_hold_q <= '0;
            j_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            gnt      <= gnt_d;
            cost_out <= cost_d;
            cost_vld <= vld_d;
            busy     <= busy_d;
            if (state_q == ST_GRANT) begin
                w_hold_q <= sel_w;
                j_hold_q <= sel_j;
            end
        end
    end

`ifdef JAM_ARB_TIMEOUT_EN
    // Idle-hold counter and forced-release flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_q      <= '0;
            timeout_err <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            timeout_err <= tmo_d;
        end
    end
`endif

endmodule

// File: tb/tb_jam_cost_rom_arbiter.sv
// Directed bench for jam_cost_rom_arbiter; the ROM is modelled as ROM[w][j] = 8*w + j.
// Build with JAM_ARB_TIMEOUT_EN defined to exercise the hold timeout (HOLD_LIMIT = 4).
module tb_jam_cost_rom_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 3;
    localparam int unsigned CWD  = 7;

    logic                 CLK;
    logic                 RST_N;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      rd;
    logic [NREQ-1:0]      last;
    logic [NREQ*AW-1:0]   w_in;
    logic [NREQ*AW-1:0]   j_in;
    logic [NREQ-1:0]      gnt;
    logic [AW-1:0]        rom_w;
    logic [AW-1:0]        rom_j;
    logic [CWD-1:0]       rom_cost;
    logic [CWD-1:0]       cost_out;
    logic [NREQ-1:0]      cost_vld;
    logic                 busy;
`ifdef JAM_ARB_TIMEOUT_EN
    logic                 timeout_err;
`endif

    int n_tests;
    int n_fail;

    jam_cost_rom_arbiter #(
        .NUM_REQ    (NREQ),
        .ADDR_W     (AW),
        .COST_W     (CWD),
`ifdef JAM_ARB_TIMEOUT_EN
        .HOLD_LIMIT (4)
`else
        .HOLD_LIMIT (16)
`endif
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .req         (req),
        .rd          (rd),
        .last        (last),
        .w_in        (w_in),
        .j_in        (j_in),
        .gnt         (gnt),
        .rom_w       (rom_w),
        .rom_j       (rom_j),
        .rom_cost    (rom_cost),
        .cost_out    (cost_out),
        .cost_vld    (cost_vld),
        .busy        (busy)
`ifdef JAM_ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    // Cost ROM: {w, j} as a 6-bit number equals 8*w + j.
    assign rom_cost = 7'({rom_w, rom_j});

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_addr(input int r, input logic [2:0] w, input logic [2:0] j);
        w_in[r*AW +: AW] = w;
        j_in[r*AW +: AW] = j;
    endtask

    // One read by requester r; checks the ROM address, then the cost one cycle later.
    task automatic do_read(input string tag, input int r, input logic [2:0] w,
                           input logic [2:0] j, input logic lst, input logic [6:0] exp_cost);
        set_addr(r, w, j);
        rd[r]   = 1'b1;
        last[r] = lst;
        #1;
        check({tag, " rom_w"}, 32'(rom_w), 32'(w));
        check({tag, " rom_j"}, 32'(rom_j), 32'(j));
        cyc();
        check({tag, " cost_out"}, 32'(cost_out), 32'(exp_cost));
        check({tag, " cost_vld"}, 32'(cost_vld), 32'(NREQ'(1) << r));
        rd[r]   = 1'b0;
        last[r] = 1'b0;
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST_N   = 1'b0;
        req     = '0;
        rd      = '0;
        last    = '0;
        w_in    = '0;
        j_in    = '0;

        // Reset values
        #12;
        check("rst gnt",      32'(gnt),      0);
        check("rst cost_vld", 32'(cost_vld), 0);
        check("rst cost_out", 32'(cost_out), 0);
        check("rst busy",     32'(busy),     0);
        check("rst rom_w",    32'(rom_w),    0);
        check("rst rom_j",    32'(rom_j),    0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Single requester: three-read burst
        req[0] = 1'b1;
        cyc();
        check("s gnt",  32'(gnt),      1);
        check("s busy", 32'(busy),     1);
        check("s vld0", 32'(cost_vld), 0);
        do_read("s0", 0, 3'd0, 3'd3, 1'b0, 7'd3);
        do_read("s1", 0, 3'd1, 3'd5, 1'b0, 7'd13);
        do_read("s2", 0, 3'd2, 3'd7, 1'b1, 7'd23);
        check("s rel gnt",  32'(gnt),  0);
        check("s rel busy", 32'(busy), 1);
        req[0] = 1'b0;
        set_addr(0, 3'd5, 3'd5);
        cyc();
        check("s idle busy", 32'(busy),     0);
        check("s idle vld",  32'(cost_vld), 0);
        check("s hold rom_w", 32'(rom_w),   2);
        check("s hold rom_j", 32'(rom_j),   7);

        // Contention with pointer at 1: requester 1 first, then requester 0
        req = 2'b11;
        cyc();
        check("c gnt1 first", 32'(gnt), 2);
        do_read("c0", 1, 3'd3, 3'd4, 1'b0, 7'd28);
        do_read("c1", 1, 3'd5, 3'd6, 1'b1, 7'd46);
        check("c rel gnt", 32'(gnt), 0);
        req[1] = 1'b0;
        cyc();
        check("c gap gnt", 32'(gnt), 0);
        cyc();
        check("c gnt0 second", 32'(gnt), 1);

        // Non-owner noise while requester 0 owns
        rd[1]   = 1'b1;
        last[1] = 1'b1;
        set_addr(1, 3'd7, 3'd7);
        do_read("n0", 0, 3'd1, 3'd2, 1'b0, 7'd10);
        cyc();
        check("n idle vld",  32'(cost_vld), 0);
        check("n idle gnt",  32'(gnt),      1);
        check("n idle cost", 32'(cost_out), 10);
        check("n rom_w",     32'(rom_w),    1);
        do_read("n1", 0, 3'd4, 3'd1, 1'b1, 7'd33);
        check("n rel gnt", 32'(gnt), 0);
        rd[1]   = 1'b0;
        last[1] = 1'b0;
        req     = 2'b10;

        // Abandon: owner 1 drops req after one read
        cyc();
        check("a idle gnt", 32'(gnt), 0);
        cyc();
        check("a gnt1", 32'(gnt), 2);
        do_read("a0", 1, 3'd6, 3'd0, 1'b0, 7'd48);
        req[1] = 1'b0;
        cyc();
        check("a rel gnt",  32'(gnt),      0);
        check("a rel vld",  32'(cost_vld), 0);
        check("a rel busy", 32'(busy),     1);
        req = 2'b11;
        cyc();
        cyc();
        check("a ptr0 gnt", 32'(gnt), 1);

        // Reset in the middle of a burst
        do_read("r0", 0, 3'd1, 3'd1, 1'b0, 7'd9);
        rd[0] = 1'b1;
        set_addr(0, 3'd2, 3'd2);
        #2;
        RST_N = 1'b0;
        #1;
        check("r gnt",  32'(gnt),      0);
        check("r vld",  32'(cost_vld), 0);
        check("r busy", 32'(busy),     0);
        check("r cost", 32'(cost_out), 0);
        @(posedge CLK);
        rd[0] = 1'b0;
        #1;
        RST_N = 1'b1;
        cyc();
        check("r regrant gnt", 32'(gnt),      1);
        check("r regrant vld", 32'(cost_vld), 0);

`ifdef JAM_ARB_TIMEOUT_EN
        // Forced release after HOLD_LIMIT idle GRANT cycles
        do_read("t0", 0, 3'd3, 3'd3, 1'b1, 7'd27);
        req = 2'b10;
        cyc();
        cyc();
        check("t gnt",  32'(gnt),         2);
        check("t tmo0", 32'(timeout_err), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t hold gnt", 32'(gnt),         2);
            check("t hold tmo", 32'(timeout_err), 0);
        end
        cyc();
        check("t rel gnt", 32'(gnt),         0);
        check("t rel tmo", 32'(timeout_err), 1);
        req = 2'b00;
        cyc();
        check("t idle tmo",  32'(timeout_err), 0);
        check("t idle busy", 32'(busy),        0);
`else
        // Without the timeout an idle owner keeps the grant indefinitely
        for (int i = 0; i < 20; i++) begin
            cyc();
        end
        check("h long hold gnt", 32'(gnt), 1);
        check("h long hold vld", 32'(cost_vld), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jam_cost_rom_arbiter.md
Name: jam_cost_rom_arbiter

Overview:
- Round-robin arbiter that shares one combinational cost ROM (8 workers x 8 jobs, 7-bit cost) between NUM_REQ job-assignment engines.
- Each engine requests the ROM, issues a burst of worker/job reads, and releases the ROM with a last-read marker.
- The arbiter muxes the owner's address onto the ROM, registers the returned cost, and steers a per-requester valid.
- Sits between the assignment engines and the single shared cost ROM at the top level.

Parameters:
NUM_REQ, 2, number of requesting engines (2..8)
ADDR_W, 3, width of worker index and of job index
COST_W, 7, cost data width
HOLD_LIMIT, 16, max consecutive idle (no-read) cycles an owner may hold the grant (used only with the optional feature)

Ports:
CLK  in  1  clock; all state on rising edge
RST_N  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request; held high for the whole burst
rd  in  NUM_REQ  per-requester read strobe; effective only while granted
last  in  NUM_REQ  marks the final read of the burst; sampled only with rd
w_in  in  NUM_REQ*ADDR_W  per-requester worker index, requester i at bits [i*ADDR_W +: ADDR_W]
j_in  in  NUM_REQ*ADDR_W  per-requester job index, same packing as w_in
gnt  out  NUM_REQ  one-hot grant, registered
rom_w  out  ADDR_W  worker address to the ROM
rom_j  out  ADDR_W  job address to the ROM
rom_cost  in  COST_W  ROM data, combinational from rom_w/rom_j
cost_out  out  COST_W  registered cost, broadcast to all requesters
cost_vld  out  NUM_REQ  one-hot; bit i high means cost_out belongs to requester i
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: gnt=0, cost_vld=0, cost_out=0, rom_w=0, rom_j=0, busy=0, RR pointer=0, state=IDLE.
- FSM states:
  - IDLE: if any req, pick the first set bit searching upward from the RR pointer, wrapping at NUM_REQ. Load the owner register. Next state GRANT; gnt[owner] rises the next cycle.
  - GRANT: rom_w/rom_j = owner's w_in/j_in (combinational mux on the owner register). A read is rd[owner] & req[owner].
    - Each read: cost_out <= rom_cost and cost_vld[owner] <= 1 on the next edge. Read-to-data latency is exactly 1 cycle, with back-to-back reads at one per cycle.
    - A cycle with no read gives cost_vld = 0.
    - A read with last[owner] goes to RELEASE.
    - req[owner] falling without last (abandon) also goes to RELEASE; no cost_vld is produced for that cycle.
  - RELEASE: gnt=0. The final read's cost_vld is asserted in this cycle. RR pointer <= owner+1, wrapping mod NUM_REQ. Next state IDLE. Minimum gap between bursts of different owners is therefore 2 cycles (RELEASE, IDLE).
- Non-owner inputs: rd/last from non-owners are ignored; no read, no error.
- Simultaneous requests: strict RR from the pointer. With all requesters active, grant order is 0,1,...,NUM_REQ-1,0.
- Same-requester re-request: if the released owner keeps req high, it is serviced again only after every other pending requester has been served.
- rom_w/rom_j in IDLE/RELEASE: hold their last values; they do not toggle.
- Reset mid-burst: everything returns to reset values immediately and asynchronously. No cost_vld is issued for in-flight reads.
- busy is a decode of the registered state.

Optional Feature:
- JAM_ARB_TIMEOUT_EN defined:
  - A hold counter (clog2(HOLD_LIMIT)+1 bits) clears on every read and on entry to GRANT, and increments on each GRANT cycle without a read.
  - When the counter reaches HOLD_LIMIT, the arbiter forces RELEASE.
  - Adds output timeout_err (1 bit, reset 0), pulsed high for exactly the RELEASE cycle of a forced release.
- JAM_ARB_TIMEOUT_EN undefined: no counter and no timeout_err port. An owner may idle in GRANT indefinitely.

Decomposition:
- Shared package jam_pkg holds:
  - ADDR_W and COST_W constants
  - the FSM state encoding (IDLE, GRANT, RELEASE)
  - the NUM_WORKERS=8 constant
- Sub-module jam_rr_picker: combinational round-robin first-set-bit search taking req and pointer, returning an index and a found flag. Instantiated once.

Test Plan:
- Single requester: req[0]=1; reads (w,j)=(0,3),(1,5),(2,7) with last on the third; ROM[w][j]=8w+j. Required: gnt[0] high from cycle 2; cost_out 3,13,23 with cost_vld=01 one cycle after each read; gnt[0]=0 in RELEASE.
- Contention: req=11 asserted together, each requester does a 2-read burst. Required: requester 0 granted first, requester 1 granted 2 cycles after requester 0's RELEASE. A second round with req=11 grants requester 1 first.
- Abandon: owner 1 drops req after 1 read, no last. Required: 1 cost_vld for that read, RELEASE next cycle, pointer=0.
- Non-owner noise: requester 1 toggles rd/last while requester 0 owns. Required: rom_w/rom_j track requester 0 only; cost_vld[1] never asserts.
- Reset mid-burst: RST_N low for 1 cycle during GRANT. Required: gnt=0, cost_vld=0, busy=0 immediately; first grant after reset goes to requester 0.
- With JAM_ARB_TIMEOUT_EN and HOLD_LIMIT=4: owner holds req with no rd. Required: forced RELEASE after 4 idle cycles, timeout_err high for 1 cycle.
